// File: rtl/spi_slave_txn_engine_if.sv
// Bundle of the SPI pins and register-file bus for spi_slave_txn_engine.
interface spi_slave_txn_engine_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  SS;
    logic                  MOSI;
    logic                  MISO;
    logic [DATA_WIDTH-1:0] Rd_Data;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Wr_Data;
    logic                  Wr_EN;
    logic                  Rd_EN;
    logic                  Busy;

    modport slave (
        input  SS, MOSI, Rd_Data,
        output MISO, Address, Wr_Data, Wr_EN, Rd_EN, Busy
    );

    modport master (
        output SS, MOSI, Rd_Data,
        input  MISO, Address, Wr_Data, Wr_EN, Rd_EN, Busy
    );
endinterface

// File: rtl/spi_slave_txn_engine.sv
// Frame-level SPI slave: command bit, address, then data words to/from a register file.
// Define SPI_BURST_EN for multi-word auto-increment frames; otherwise one word per frame.
module spi_slave_txn_engine #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                  SCLK,
    input logic                  RST,
    spi_slave_txn_engine_if.slave spi
);
    localparam int unsigned MaxW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CntW = $clog2(MaxW) + 1;
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StTurn, StWdata, StRdata, StDone
    } state_e;

    logic ss, mosi;
    assign ss   = spi.SS;
    assign mosi = spi.MOSI;

    // Frame state: cleared asynchronously by RST or SS.
    state_e                st_q, st_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [MaxW-1:0]       rx_q, rx_d, rx_shift;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] pre_q, pre_d;
    logic                  rw_q, rw_d;
    logic                  wrote_q, wrote_d;
    logic                  busy_q;

    // Register-file side: survives SS, cleared only by RST.
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q + 1'b1;
        rx_shift = {rx_q[MaxW-2:0], mosi};
        rx_d     = rx_q;
        tx_d     = tx_q;
        pre_d    = pre_q;
        rw_d     = rw_q;
        wrote_d  = wrote_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        unique case (st_q)
            // IDLE with SS low behaves as CMD, so the first edge is the R/W bit.
            StIdle, StCmd: begin
                rw_d  = mosi;
                st_d  = StAddr;
                cnt_d = '0;
            end
            StAddr: begin
                rx_d = rx_shift;
                if (cnt_q == AddrLast) begin
                    addr_d  = rx_shift[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    st_d    = rw_q ? StWdata : StTurn;
                    rd_en_d = ~rw_q;
                end
            end
            StTurn: begin
                tx_d  = spi.Rd_Data;
                cnt_d = '0;
                st_d  = StRdata;
            end
            StWdata: begin
                rx_d = rx_shift;
                if (cnt_q == '0 && wrote_q) begin
                    addr_d = addr_q + 1'b1;
                end
                if (cnt_q == DataLast) begin
                    wdata_d = rx_shift[DATA_WIDTH-1:0];
                    wr_en_d = 1'b1;
                    wrote_d = 1'b1;
                    cnt_d   = '0;
`ifndef SPI_BURST_EN
                    st_d    = StDone;
`endif
                end
            end
            StRdata: begin
                tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
`ifdef SPI_BURST_EN
                if (cnt_q == '0) begin
                    addr_d  = addr_q + 1'b1;
                    rd_en_d = 1'b1;
                end
                if (cnt_q == CntW'(1)) begin
                    pre_d = spi.Rd_Data;
                end
                if (cnt_q == DataLast) begin
                    tx_d  = pre_q;
                    cnt_d = '0;
                end
`else
                if (cnt_q == DataLast) begin
                    tx_d = '0;
                    st_d = StDone;
                end
`endif
            end
            StDone: begin
                tx_d  = '0;
                cnt_d = cnt_q;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge SCLK or posedge RST or posedge ss) begin
        if (RST || ss) begin
            st_q    <= StIdle;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            pre_q   <= '0;
            rw_q    <= 1'b0;
            wrote_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            pre_q   <= pre_d;
            rw_q    <= rw_d;
            wrote_q <= wrote_d;
            busy_q  <= 1'b1;
        end
    end

    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign spi.MISO    = tx_q[DATA_WIDTH-1];
    assign spi.Address = addr_q;
    assign spi.Wr_Data = wdata_q;
    assign spi.Wr_EN   = wr_en_q;
    assign spi.Rd_EN   = rd_en_q;
    assign spi.Busy    = busy_q;
endmodule

// File: tb/tb_spi_slave_txn_engine.sv
// Directed bench for spi_slave_txn_engine (8-bit address/data); burst cases under SPI_BURST_EN.
module tb_spi_slave_txn_engine;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   cmp  = 0;
    int   mism = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] wr_addr [0:7];
    logic [7:0] wr_data [0:7];

    spi_slave_txn_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    spi_slave_txn_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .SCLK (sclk),
        .RST  (rst),
        .spi  (bus)
    );

    // Register-file model: read data is the inverted address.
    assign bus.Rd_Data = bus.Address ^ 8'hFF;

    always #5 sclk = ~sclk;

    // One-cycle strobes are seen at exactly one falling edge.
    always @(negedge sclk) begin
        if (bus.Wr_EN === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = bus.Address;
                wr_data[wr_cnt] = bus.Wr_Data;
            end
            wr_cnt++;
        end
        if (bus.Rd_EN === 1'b1) rd_cnt++;
    end

    // Called at posedge+1 with SS low; cap[n-1] is what the master samples at edge 1.
    task automatic shift_frame(input logic [39:0] bits, input int n, output logic [39:0] cap);
        cap = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.MOSI = bits[i];
            cap = {cap[38:0], bus.MISO};
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic idle_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic test_reset;
        idle_edges(2);
        cmp++; if (bus.Address !== 8'h00) begin mism++; $display("FAIL reset_addr got %h want 00", bus.Address); end
        cmp++; if (bus.Wr_Data !== 8'h00) begin mism++; $display("FAIL reset_wdata got %h want 00", bus.Wr_Data); end
        cmp++; if ({bus.Wr_EN, bus.Rd_EN, bus.MISO, bus.Busy} !== 4'b0000) begin
            mism++; $display("FAIL reset_flags got %b want 0000", {bus.Wr_EN, bus.Rd_EN, bus.MISO, bus.Busy});
        end
        rst = 1'b0;
        idle_edges(1);
    endtask

    task automatic test_single_write(input logic [7:0] a, input logic [7:0] d);
        logic [39:0] cap;
        wr_cnt = 0;
        bus.SS = 1'b0;
        shift_frame({23'd0, 1'b1, a, d}, 17, cap);
        cmp++; if (bus.Wr_EN !== 1'b1) begin mism++; $display("FAIL wr_strobe got %b want 1", bus.Wr_EN); end
        cmp++; if (bus.Address !== a) begin mism++; $display("FAIL wr_addr got %h want %h", bus.Address, a); end
        cmp++; if (bus.Wr_Data !== d) begin mism++; $display("FAIL wr_data got %h want %h", bus.Wr_Data, d); end
        cmp++; if (bus.Busy !== 1'b1) begin mism++; $display("FAIL wr_busy got %b want 1", bus.Busy); end
        bus.SS = 1'b1;
        #1;
        cmp++; if (bus.Busy !== 1'b0) begin mism++; $display("FAIL wr_busy_ss got %b want 0", bus.Busy); end
        idle_edges(2);
        cmp++; if (bus.Wr_EN !== 1'b0) begin mism++; $display("FAIL wr_strobe_clr got %b want 0", bus.Wr_EN); end
        cmp++; if (wr_cnt !== 1) begin mism++; $display("FAIL wr_pulses got %0d want 1", wr_cnt); end
    endtask

    task automatic test_read;
        logic [39:0] cap;
        rd_cnt = 0;
        wr_cnt = 0;
        bus.SS = 1'b0;
        shift_frame({31'd0, 1'b0, 8'h10}, 9, cap);
        cmp++; if (bus.Rd_EN !== 1'b1) begin mism++; $display("FAIL rd_strobe got %b want 1", bus.Rd_EN); end
        cmp++; if (bus.Address !== 8'h10) begin mism++; $display("FAIL rd_addr got %h want 10", bus.Address); end
`ifdef SPI_BURST_EN
        shift_frame(40'd0, 25, cap);
        cmp++; if (cap[23:0] !== 24'hEFEEED) begin mism++; $display("FAIL rd_burst_data got %h want efeeed", cap[23:0]); end
        cmp++; if (bus.Address !== 8'h13) begin mism++; $display("FAIL rd_burst_addr got %h want 13", bus.Address); end
        bus.SS = 1'b1;
        idle_edges(2);
        cmp++; if (rd_cnt !== 4) begin mism++; $display("FAIL rd_burst_pulses got %0d want 4", rd_cnt); end
`else
        shift_frame(40'd0, 9, cap);
        cmp++; if (cap[7:0] !== 8'hEF) begin mism++; $display("FAIL rd_data got %h want ef", cap[7:0]); end
        shift_frame(40'hFF_FFFF_FFFF, 8, cap);
        cmp++; if (cap[7:0] !== 8'h00) begin mism++; $display("FAIL rd_done_miso got %h want 00", cap[7:0]); end
        cmp++; if (bus.Address !== 8'h10) begin mism++; $display("FAIL rd_done_addr got %h want 10", bus.Address); end
        cmp++; if (bus.Busy !== 1'b1) begin mism++; $display("FAIL rd_done_busy got %b want 1", bus.Busy); end
        bus.SS = 1'b1;
        idle_edges(2);
        cmp++; if (rd_cnt !== 1) begin mism++; $display("FAIL rd_pulses got %0d want 1", rd_cnt); end
        cmp++; if (wr_cnt !== 0) begin mism++; $display("FAIL rd_no_write got %0d want 0", wr_cnt); end
`endif
    endtask

    task automatic test_abort;
        logic [39:0] cap;
        wr_cnt = 0;
        bus.SS = 1'b0;
        shift_frame({27'd0, 1'b1, 8'h20, 4'hA}, 13, cap);
        bus.SS = 1'b1;
        #1;
        cmp++; if (bus.Busy !== 1'b0) begin mism++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
        idle_edges(2);
        cmp++; if (wr_cnt !== 0) begin mism++; $display("FAIL abort_pulses got %0d want 0", wr_cnt); end
        cmp++; if (bus.Wr_Data !== 8'hA5) begin mism++; $display("FAIL abort_wdata got %h want a5", bus.Wr_Data); end
        cmp++; if (bus.Address !== 8'h20) begin mism++; $display("FAIL abort_addr got %h want 20", bus.Address); end
        test_single_write(8'h55, 8'h5A);
    endtask

    task automatic test_rst_mid_read;
        logic [39:0] cap;
        bus.SS = 1'b0;
        shift_frame({28'd0, 1'b0, 8'h40, 3'b000}, 12, cap);
        cmp++; if (bus.MISO !== 1'b1) begin mism++; $display("FAIL rstrd_miso_pre got %b want 1", bus.MISO); end
        rst = 1'b1;
        #1;
        cmp++; if (bus.Address !== 8'h00) begin mism++; $display("FAIL rstrd_addr got %h want 00", bus.Address); end
        cmp++; if (bus.Wr_Data !== 8'h00) begin mism++; $display("FAIL rstrd_wdata got %h want 00", bus.Wr_Data); end
        cmp++; if ({bus.Wr_EN, bus.Rd_EN, bus.MISO, bus.Busy} !== 4'b0000) begin
            mism++; $display("FAIL rstrd_flags got %b want 0000", {bus.Wr_EN, bus.Rd_EN, bus.MISO, bus.Busy});
        end
        idle_edges(1);
        rst = 1'b0;
        bus.SS = 1'b1;
        idle_edges(2);
        test_single_write(8'h07, 8'h3E);
    endtask

`ifdef SPI_BURST_EN
    task automatic test_burst_write;
        logic [39:0] cap;
        wr_cnt = 0;
        bus.SS = 1'b0;
        shift_frame({7'd0, 1'b1, 8'hFE, 8'h11, 8'h22, 8'h33}, 33, cap);
        bus.SS = 1'b1;
        idle_edges(2);
        cmp++; if (wr_cnt !== 3) begin mism++; $display("FAIL bw_pulses got %0d want 3", wr_cnt); end
        cmp++; if ({wr_addr[0], wr_addr[1], wr_addr[2]} !== 24'hFEFF00) begin
            mism++; $display("FAIL bw_addr got %h want feff00", {wr_addr[0], wr_addr[1], wr_addr[2]});
        end
        cmp++; if ({wr_data[0], wr_data[1], wr_data[2]} !== 24'h112233) begin
            mism++; $display("FAIL bw_data got %h want 112233", {wr_data[0], wr_data[1], wr_data[2]});
        end
    endtask
`else
    task automatic test_single_word_only;
        logic [39:0] cap;
        wr_cnt = 0;
        bus.SS = 1'b0;
        shift_frame({23'd0, 1'b1, 8'h80, 8'hC3, 8'h99}, 25, cap);
        cmp++; if (bus.Address !== 8'h80) begin mism++; $display("FAIL sw_addr got %h want 80", bus.Address); end
        cmp++; if (bus.Wr_Data !== 8'hC3) begin mism++; $display("FAIL sw_wdata got %h want c3", bus.Wr_Data); end
        bus.SS = 1'b1;
        idle_edges(2);
        cmp++; if (wr_cnt !== 1) begin mism++; $display("FAIL sw_pulses got %0d want 1", wr_cnt); end
        cmp++; if (wr_addr[0] !== 8'h80) begin mism++; $display("FAIL sw_wr_addr got %h want 80", wr_addr[0]); end
    endtask
`endif

    initial begin
        bus.SS   = 1'b1;
        bus.MOSI = 1'b0;
        @(posedge sclk);
        #1;
        test_reset();
        test_single_write(8'h3C, 8'hA5);
        test_abort();
        test_read();
`ifdef SPI_BURST_EN
        test_burst_write();
`else
        test_single_word_only();
`endif
        test_rst_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule

// File: doc/spi_slave_txn_engine.md
# spi_slave_txn_engine

Frame-level SPI slave transaction engine, sitting between the SPI pins and the register file, with a single SCLK clock domain. Each SS-low frame carries a command bit, an address and one or more data words, with independent address and data widths. It deserialises MOSI, drives register-file write and read strobes, and serialises read data onto MISO. Multi-word frames auto-increment the address for both reads and writes.

## Interface
- ADDR_WIDTH, 8: address field and Address bus width, ≥1.
- DATA_WIDTH, 8: data word width, ≥4.
- SCLK input 1: SPI clock; all sequential logic on posedge.
- RST input 1: asynchronous, active-high reset.
- SS input 1: slave select, active low; high asynchronously aborts the frame.
- MOSI input 1: serial data in, MSB first, sampled on posedge SCLK.
- MISO output 1: serial data out, MSB first; updates on posedge, master samples on the following posedge.
- Rd_Data input DATA_WIDTH: register-file combinational read data for Address.
- Address output ADDR_WIDTH: register-file address.
- Wr_Data output DATA_WIDTH: register-file write data.
- Wr_EN output 1: one-cycle write strobe.
- Rd_EN output 1: one-cycle read strobe; Rd_Data is captured on the next edge.
- Busy output 1: a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, CMD, ADDR, TURN, WDATA, RDATA.
- SS high (async):
  - state is forced to IDLE, and bit counter, rx/tx shifters, prefetch register, MISO and Busy are cleared;
  - Address, Wr_Data, Wr_EN and Rd_EN are not cleared by SS.
- IDLE → CMD when SS is low. IDLE/CMD is an asynchronous transition: CMD consumes edge 1.
- CMD: edge 1 samples MOSI as the R/W bit (1 = write, 0 = read) and moves to ADDR.
- ADDR:
  - edges 2..ADDR_WIDTH+1 shift in the address, MSB first.
  - The last edge loads Address and goes to WDATA (write) or TURN (read).
  - On a read, that last edge also sets Rd_EN=1.
- TURN: one edge. It loads tx shifter ← Rd_Data and clears Rd_EN. MISO then presents bit DATA_WIDTH-1, and the state moves to RDATA.
- WDATA:
  - Each edge shifts MOSI into the rx shifter.
  - On the DATA_WIDTH-th bit of a word: Wr_Data ← {rx, MOSI}, Wr_EN=1.
  - On the first bit of the next word: Wr_EN=0 and Address ← Address+1.
- RDATA:
  - Edge 1 of a word shifts the tx shifter and sets Address ← Address+1, Rd_EN=1 (prefetch).
  - Edge 2 captures the prefetch register ← Rd_Data and sets Rd_EN=0.
  - Intermediate edges shift.
  - Edge DATA_WIDTH loads the tx shifter ← prefetch, starting the next word.
  - MOSI is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- Wr_EN and Rd_EN are cleared only by the next posedge SCLK or by RST. A strobe set on the last edge before SS rises therefore stays high until the next SCLK edge; the register file samples it there.
- Partial words at SS rise are discarded: no Wr_EN is issued and Wr_Data is unchanged.
- Bit counter width is $clog2(max(ADDR_WIDTH, DATA_WIDTH))+1 and resets to 0 on each state or word boundary.

## Timing
- Reset values: Address=0, Wr_Data=0, Wr_EN=0, Rd_EN=0, MISO=0, Busy=0, state=IDLE.
- Write, first word: Wr_EN high after edge ADDR_WIDTH+DATA_WIDTH+1, for exactly one cycle. Address is stable while Wr_EN is high.
- Read, first word: Rd_EN is high between edges ADDR_WIDTH+1 and ADDR_WIDTH+2. The master samples MISO data bit DATA_WIDTH-1 at edge ADDR_WIDTH+3 and bit 0 at edge ADDR_WIDTH+DATA_WIDTH+2.
- Burst words are back-to-back, with no gap cycles.
- RST is asynchronous and overrides SS. Asserting RST mid-frame returns the block to reset values; after RST falls, the next frame needs an SS high→low.

## Configuration
- SPI_BURST_EN defined: multi-word frames with auto-increment, as above.
- SPI_BURST_EN undefined:
  - after the first data word the FSM enters a DONE hold (Busy=1);
  - it ignores MOSI, drives MISO=0, issues no further strobes and no address increment, until SS rises.

## Test plan
All scenarios use ADDR_WIDTH=8, DATA_WIDTH=8.
- Single write: bits 1, 0x3C, 0xA5 → exactly one Wr_EN pulse after edge 17, with Address=0x3C and Wr_Data=0xA5.
- Burst write (SPI_BURST_EN): 1, 0xFE, 0x11, 0x22, 0x33 → writes at 0xFE, 0xFF, 0x00 (wrap), each one cycle.
- Burst read, register-file model returns addr^0xFF: 0, 0x10, turn bit, then 24 clocks → MISO yields 0xEF, 0xEE, 0xED, and the Rd_EN pulse count is 3 (+1 trailing prefetch).
- SS abort after 4 data bits of a write word → no Wr_EN, Wr_Data retains its old value, Busy=0 immediately, and the next frame decodes correctly.
- RST pulse mid-read → all outputs return to reset values asynchronously; MISO=0.
- SPI_BURST_EN undefined, 2-word write → only the first word is written, and Address is unchanged afterwards.
